fetch_stage: RTL

Instruction-fetch stage of the 32-bit RISC-V pipeline. It owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small prefetch FIFO. The FIFO head drives `InstrF`/`PCF` into the IF/ID pipeline register. The stage honours decode-stage stalls and execute-stage branch/jump redirects, discarding wrong-path fetches.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 32-bit RISC-V pipeline.
// Owns the fetch PC, issues one-at-a-time word requests to instruction
// memory, and buffers returned words with their PCs in a small prefetch FIFO
// whose head feeds the IF/ID register.
// Build option: define FETCH_BUBBLE_NOP_EN to present addi x0,x0,0 (0x13)
// on InstrF when no valid instruction is available; otherwise 0 is shown.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | just out of reset, no request yet
// S_FETCH    | no request outstanding, may issue one
// S_WAIT     | one request granted, waiting for its response
// S_WAIT_DROP| outstanding response belongs to a squashed path; discard it

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        ValidF
);

    localparam int AW = $clog2(DEPTH);
`ifdef FETCH_BUBBLE_NOP_EN
    localparam logic [31:0] FILL_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] FILL_INSTR = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WAIT_DROP
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic          head_valid;
    logic          pop;
    logic          push;
    logic          space;
    logic          grant;
    logic [AW:0]   occ_next;
    logic [31:0]   target_pc;

    // Handshake and FIFO occupancy decisions for the current cycle.
    // A redirect masks the head and suppresses any new request.
    always_comb begin
        head_valid = (count != '0) && !PCSrcE;
        pop        = head_valid && !StallD;
        push       = (state == S_WAIT) && imem_rvalid;
        occ_next   = count + (AW+1)'(push) - (AW+1)'(pop);
        space      = occ_next < (AW+1)'(DEPTH);
        imem_req   = ((state == S_FETCH) || push) && space && !PCSrcE;
        grant      = imem_req && imem_gnt;
        target_pc  = PCTargetE & ~32'h0000_0003;
    end

    assign imem_addr = fetch_pc;
    assign ValidF    = head_valid;
    assign InstrF    = head_valid ? fifo_instr[rd_ptr] : FILL_INSTR;
    assign PCF       = head_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;

    // Control FSM, fetch PC, outstanding-request PC and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC & ~32'h0000_0003;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (!PCSrcE && grant)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (PCSrcE)
                        state <= imem_rvalid ? S_FETCH : S_WAIT_DROP;
                    else if (imem_rvalid)
                        state <= grant ? S_WAIT : S_FETCH;
                end
                S_WAIT_DROP: begin
                    // A redirect here only moves fetch_pc; the wrong-path
                    // response still has to be drained.
                    if (imem_rvalid)
                        state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase

            if (PCSrcE) begin
                fetch_pc <= target_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (grant) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= occ_next;
            end
        end
    end

    // FIFO payload storage; contents are qualified by count, so no reset.
    always_ff @(posedge clk) begin
        if (rst && !PCSrcE && push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
